ca4_serial_tx: RTL and testbench

Serial frame transmitter for the CA4 link: accepts a 2-bit destination address and a 4-bit payload on a load/ready handshake and shifts a framed bitstream out on one serial line, MSB first. It is the sending end of the line that the CA4 receiver samples on `serIn`, and drives that net directly. Line idles high. One frame carries one value for one of the receiver's four 4-bit outputs (L0–L3).

---
 rtl/ca4_pkg.sv | 25 ++
 rtl/ca4_tx_shifter.sv | 29 ++
 rtl/ca4_serial_tx.sv | 172 +++++++++++++++++
 tb/tb_ca4_serial_tx.sv | 208 ++++++++++++++++++++
 4 files changed

// File: rtl/ca4_pkg.sv
// Shared CA4 link definitions: transmitter state encoding, framing constants and parity helper.
// Used by both ends of the link so frame layout stays in one place.
package ca4_pkg;

  typedef enum logic [2:0] {
    CA4_ST_IDLE  = 3'd0,
    CA4_ST_START = 3'd1,
    CA4_ST_ADDR  = 3'd2,
    CA4_ST_DATA  = 3'd3,
    CA4_ST_PAR   = 3'd4,
    CA4_ST_STOP  = 3'd5
  } ca4_tx_state_t;

  localparam logic        CA4_START_BIT  = 1'b0;
  localparam logic        CA4_STOP_BIT   = 1'b1;
  localparam int unsigned CA4_ADDR_W     = 2;
  localparam int unsigned CA4_DATA_W     = 4;
  localparam int unsigned CA4_FRAME_BITS = 8;

  // Even parity: bit that makes the total count of ones even.
  function automatic logic ca4_parity(input logic [CA4_ADDR_W+CA4_DATA_W-1:0] bits);
    return ^bits;
  endfunction

endpackage

// File: rtl/ca4_tx_shifter.sv
// CA4 transmit shift register: parallel load of {addr,data}, left shift, MSB presented.
module ca4_tx_shifter
  import ca4_pkg::*;
(
  input  logic                             i_clk,
  input  logic                             i_rst_n,
  input  logic                             i_load,
  input  logic                             i_shift,
  input  logic [CA4_ADDR_W+CA4_DATA_W-1:0] i_data,
  output logic                             o_msb
);

  localparam int unsigned W = CA4_ADDR_W + CA4_DATA_W;

  logic [W-1:0] r_q;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_data;
    end else if (i_shift) begin
      r_q <= {r_q[W-2:0], 1'b0};
    end
  end

  assign o_msb = r_q[W-1];

endmodule

// File: rtl/ca4_serial_tx.sv
// CA4 serial frame transmitter: start, 2 addr bits, 4 data bits, optional parity, stop; MSB first.
// Build option: define CA4_SERIAL_TX_PARITY_EN to add an even-parity bit before the stop bit.
module ca4_serial_tx
  import ca4_pkg::*;
(
  input  logic       CLK,
  input  logic       RST,
  input  logic       load,
  input  logic [1:0] addr,
  input  logic [3:0] data,
  input  logic       abort,
  output logic       serOut,
  output logic       ready,
  output logic       busy,
  output logic       done
);

  localparam int unsigned FRAME_BITS = CA4_FRAME_BITS;

  localparam logic [2:0] ST_IDLE  = CA4_ST_IDLE;
  localparam logic [2:0] ST_START = CA4_ST_START;
  localparam logic [2:0] ST_ADDR  = CA4_ST_ADDR;
  localparam logic [2:0] ST_DATA  = CA4_ST_DATA;
  localparam logic [2:0] ST_STOP  = CA4_ST_STOP;
`ifdef CA4_SERIAL_TX_PARITY_EN
  localparam logic [2:0] ST_PAR   = CA4_ST_PAR;
`endif

  // Last bit-counter value in each shifting state.
  localparam logic [1:0] ADDR_LAST = 2'(CA4_ADDR_W - 1);
  localparam logic [1:0] DATA_LAST = 2'(FRAME_BITS - CA4_ADDR_W - 3);

  logic [2:0] r_state, w_state_d;
  logic [1:0] r_cnt, w_cnt_d;
  logic       r_ser, w_ser_d;
  logic       r_busy, w_busy_d;
  logic       r_done, w_done_d;
  logic       w_accept;
  logic       w_shift;
  logic       w_msb;

`ifdef CA4_SERIAL_TX_PARITY_EN
  logic       r_par;
`endif

  assign ready    = (r_state == ST_IDLE) || (r_state == ST_STOP);
  assign w_accept = load && ready && !abort;

  ca4_tx_shifter u_shifter (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_load  (w_accept),
    .i_shift (w_shift),
    .i_data  ({addr, data}),
    .o_msb   (w_msb)
  );

  always_comb begin
    w_state_d = r_state;
    w_cnt_d   = r_cnt;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) w_state_d = ST_START;
      end
      ST_START: begin
        w_state_d = ST_ADDR;
        w_cnt_d   = '0;
      end
      ST_ADDR: begin
        if (r_cnt == ADDR_LAST) begin
          w_state_d = ST_DATA;
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 2'd1;
        end
      end
      ST_DATA: begin
        if (r_cnt == DATA_LAST) begin
`ifdef CA4_SERIAL_TX_PARITY_EN
          w_state_d = ST_PAR;
`else
          w_state_d = ST_STOP;
`endif
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + 2'd1;
        end
      end
`ifdef CA4_SERIAL_TX_PARITY_EN
      ST_PAR: begin
        w_state_d = ST_STOP;
      end
`endif
      ST_STOP: begin
        w_state_d = w_accept ? ST_START : ST_IDLE;
        w_cnt_d   = '0;
      end
      default: begin
        w_state_d = ST_IDLE;
        w_cnt_d   = '0;
      end
    endcase
    if (abort) begin
      w_state_d = ST_IDLE;
      w_cnt_d   = '0;
    end
  end

  // Output registers are loaded with what the upcoming state drives, so every output is a flop.
  // The shifter advances on the same edge its MSB is captured, exposing the next bit.
  always_comb begin
    w_ser_d  = CA4_STOP_BIT;
    w_busy_d = 1'b0;
    w_done_d = 1'b0;
    w_shift  = 1'b0;
    case (w_state_d)
      ST_START: begin
        w_ser_d  = CA4_START_BIT;
        w_busy_d = 1'b1;
      end
      ST_ADDR, ST_DATA: begin
        w_ser_d  = w_msb;
        w_busy_d = 1'b1;
        w_shift  = 1'b1;
      end
`ifdef CA4_SERIAL_TX_PARITY_EN
      ST_PAR: begin
        w_ser_d  = r_par;
        w_busy_d = 1'b1;
      end
`endif
      ST_STOP: begin
        w_ser_d  = CA4_STOP_BIT;
        w_done_d = 1'b1;
      end
      default: begin
        w_ser_d = CA4_STOP_BIT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ser   <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_d;
      r_cnt   <= w_cnt_d;
      r_ser   <= w_ser_d;
      r_busy  <= w_busy_d;
      r_done  <= w_done_d;
    end
  end

`ifdef CA4_SERIAL_TX_PARITY_EN
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_par <= 1'b0;
    end else if (w_accept) begin
      r_par <= ca4_parity({addr, data});
    end
  end
`endif

  assign serOut = r_ser;
  assign busy   = r_busy;
  assign done   = r_done;

endmodule

// File: tb/tb_ca4_serial_tx.sv
// Self-checking bench for ca4_serial_tx: per-cycle expected line state is queued on accept
// and compared every falling edge; an empty queue means the line must be idle.
module tb_ca4_serial_tx;

  logic       CLK;
  logic       RST;
  logic       load;
  logic [1:0] addr;
  logic [3:0] data;
  logic       abort;
  logic       serOut;
  logic       ready;
  logic       busy;
  logic       done;

  typedef struct packed {
    logic ser;
    logic bsy;
    logic dn;
    logic rdy;
  } exp_t;

  localparam exp_t IdleE = '{1'b1, 1'b0, 1'b0, 1'b1};

  exp_t q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  bit   mon_en   = 1'b0;

  ca4_serial_tx dut (
    .CLK    (CLK),
    .RST    (RST),
    .load   (load),
    .addr   (addr),
    .data   (data),
    .abort  (abort),
    .serOut (serOut),
    .ready  (ready),
    .busy   (busy),
    .done   (done)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic push_frame(input logic [1:0] a, input logic [3:0] d);
    logic [5:0] v;
    v = {a, d};
    q.push_back('{1'b0, 1'b1, 1'b0, 1'b0});
    for (int i = 5; i >= 0; i--) q.push_back('{v[i], 1'b1, 1'b0, 1'b0});
`ifdef CA4_SERIAL_TX_PARITY_EN
    q.push_back('{^v, 1'b1, 1'b0, 1'b0});
`endif
    q.push_back('{1'b1, 1'b0, 1'b1, 1'b1});
  endtask

  // Holds load until the model says the transmitter is free (idle or in its stop bit).
  task automatic send(input logic [1:0] a, input logic [3:0] d);
    bit ok;
    ok = 1'b0;
    @(negedge CLK);
    load = 1'b1;
    addr = a;
    data = d;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(posedge CLK);
      if (q.size() == 0) begin
        push_frame(a, d);
        ok = 1'b1;
      end
    end
    if (!ok) check("accept_timeout", 8'd0, 8'd1);
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge CLK);
      if (q.size() == 0) ok = 1'b1;
    end
    if (!ok) check("drain_timeout", 8'd0, 8'd1);
    repeat (3) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    exp_t e;
    if (mon_en && RST) begin
      e = (q.size() > 0) ? q.pop_front() : IdleE;
      check("serOut", 8'(serOut), 8'(e.ser));
      check("busy",   8'(busy),   8'(e.bsy));
      check("done",   8'(done),   8'(e.dn));
      check("ready",  8'(ready),  8'(e.rdy));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    RST   = 1'b0;
    load  = 1'b1;
    addr  = 2'd1;
    data  = 4'h5;
    abort = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      check("rst_serOut", 8'(serOut), 8'd1);
      check("rst_ready",  8'(ready),  8'd1);
      check("rst_busy",   8'(busy),   8'd0);
      check("rst_done",   8'(done),   8'd0);
    end
    load   = 1'b0;
    RST    = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge CLK);

    // Single frame
    send(2'b01, 4'b1011);
    @(negedge CLK);
    load = 1'b0;
    drain();

    // Back-to-back frames with load held
    send(2'd3, 4'h0);
    send(2'd0, 4'hF);
    @(negedge CLK);
    load = 1'b0;
    drain();

    // Abort during DATA, then a clean frame
    send(2'd1, 4'hA);
    @(negedge CLK);
    load = 1'b0;
    repeat (3) @(negedge CLK);
    abort = 1'b1;
    @(posedge CLK);
    q.delete();
    @(negedge CLK);
    abort = 1'b0;
    repeat (2) @(negedge CLK);
    send(2'd2, 4'h6);
    @(negedge CLK);
    load = 1'b0;
    drain();

    // Load while busy is ignored, changed inputs do not disturb the frame
    send(2'd2, 4'h3);
    @(negedge CLK);
    load = 1'b0;
    @(negedge CLK);
    load = 1'b1;
    data = 4'h5;
    addr = 2'd1;
    @(negedge CLK);
    load = 1'b0;
    drain();

`ifdef CA4_SERIAL_TX_PARITY_EN
    send(2'b11, 4'b0001);
    @(negedge CLK);
    load = 1'b0;
    drain();
    send(2'b00, 4'b0011);
    @(negedge CLK);
    load = 1'b0;
    drain();
`endif

    // Asynchronous reset mid-frame
    send(2'd1, 4'h4);
    @(negedge CLK);
    load = 1'b0;
    @(negedge CLK);
    #1;
    RST = 1'b0;
    q.delete();
    #1;
    check("mid_rst_serOut", 8'(serOut), 8'd1);
    check("mid_rst_ready",  8'(ready),  8'd1);
    check("mid_rst_busy",   8'(busy),   8'd0);
    check("mid_rst_done",   8'(done),   8'd0);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    repeat (4) @(negedge CLK);

    send(2'd0, 4'h9);
    @(negedge CLK);
    load = 1'b0;
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
